// File: rtl/fft_band_energy.sv
// Purpose: turns the streamed FFT spectrum into one saturating energy word per frequency band per frame.
// Latency: the first band word is valid 4 clk edges after the edge that sampled the last used bin (index 2^(IDX_W-1)-1).
// Backpressure: each word is held until band_valid & band_ready; a frame that completes while the output bank is still draining is dropped and overrun pulses.
module fft_band_energy #(
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 10,
  parameter int NUM_BANDS = 8,
  parameter int ACC_W     = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dv,
  input  logic [IDX_W-1:0]             xk_index,
  input  logic signed [DATA_W-1:0]     xk_re,
  input  logic signed [DATA_W-1:0]     xk_im,
  output logic                         band_valid,
  input  logic                         band_ready,
  output logic [$clog2(NUM_BANDS)-1:0] band_id,
  output logic [ACC_W-1:0]             band_energy,
  output logic                         frame_err,
  output logic                         overrun
);

  localparam int BAND_W  = $clog2(NUM_BANDS);
  localparam int ABS_W   = DATA_W + 1;
  localparam int HALF    = 1 << (IDX_W - 1);
  localparam int BAND_SH = IDX_W - 1 - BAND_W;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(HALF - 1);
  localparam logic [IDX_W-1:0]  TAIL_IDX = '1;
  localparam logic [ACC_W-1:0]  ACC_MAX  = '1;
  localparam logic [BAND_W-1:0] TOP_BAND = BAND_W'(NUM_BANDS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, WAIT_TAIL} in_state_t;
  typedef enum logic       {OUT_IDLE, OUT_SEND}     out_state_t;

  // Stage 1 payload: absolute values plus routing/framing tags.
  typedef struct packed {
    logic [ABS_W-1:0]  a;
    logic [ABS_W-1:0]  b;
    logic [BAND_W-1:0] band;
    logic              first;
    logic              last;
  } s1_t;

  // Stage 2 payload: approximated magnitude plus the same tags.
  typedef struct packed {
    logic [ABS_W-1:0]  mag;
    logic [BAND_W-1:0] band;
    logic              first;
    logic              last;
  } s2_t;

  // |v| widened by one bit so that the most negative input maps to +2^(DATA_W-1).
  function automatic logic [ABS_W-1:0] abs_ext(input logic signed [DATA_W-1:0] v);
    logic [ABS_W-1:0] w;
    w = {v[DATA_W-1], v};
    return v[DATA_W-1] ? ((~w) + ABS_W'(1)) : w;
  endfunction

  in_state_t        in_state, in_next;
  logic [IDX_W-1:0] prev_idx;
  logic [IDX_W-1:0] exp_idx;
  logic             feed, feed_first, feed_last;
  logic             abort, err_det;

  s1_t              s1_dat;
  logic             s1_vld;
  s2_t              s2_dat;
  logic             s2_vld;
  logic [ABS_W-1:0] mx, mn, mag_c;

  logic [ACC_W-1:0] acc  [NUM_BANDS];
  logic [ACC_W-1:0] bank [NUM_BANDS];
  logic [ACC_W:0]   sum_c;
  logic             xfer;
  logic             bank_load;

  out_state_t        out_state, out_next;
  logic [BAND_W-1:0] id_next;

  assign exp_idx = prev_idx + IDX_W'(1);

  // Input framing: decide which bins enter the pipe and detect index discontinuities.
  always_comb begin
    in_next    = in_state;
    feed       = 1'b0;
    feed_first = 1'b0;
    feed_last  = 1'b0;
    abort      = 1'b0;
    err_det    = 1'b0;
    case (in_state)
      IDLE: begin
        // Only a bin 0 can open a frame; anything else is skipped while resynchronising.
        if (dv && xk_index == '0) begin
          in_next    = ACCUM;
          feed       = 1'b1;
          feed_first = 1'b1;
        end
      end
      ACCUM: begin
        if (dv) begin
          if (xk_index == exp_idx) begin
            feed = 1'b1;
            if (xk_index == LAST_IDX) begin
              feed_last = 1'b1;
              in_next   = WAIT_TAIL;
            end
          end else if (xk_index == '0) begin
            // A fresh frame start mid-frame silently restarts accumulation.
            abort      = 1'b1;
            feed       = 1'b1;
            feed_first = 1'b1;
          end else begin
            abort   = 1'b1;
            err_det = 1'b1;
            in_next = IDLE;
          end
        end
      end
      WAIT_TAIL: begin
        // Mirror half of the spectrum: only continuity matters, the result is already complete.
        if (dv) begin
          if (xk_index != exp_idx) begin
            err_det = 1'b1;
            in_next = IDLE;
          end else if (xk_index == TAIL_IDX) begin
            in_next = IDLE;
          end
        end
      end
      default: in_next = IDLE;
    endcase
  end

  // Input FSM state, last seen index and the frame_err pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_state  <= IDLE;
      prev_idx  <= '0;
      frame_err <= 1'b0;
    end else begin
      in_state  <= in_next;
      frame_err <= err_det;
      if (dv) prev_idx <= xk_index;
    end
  end

  // S1: absolute values, band select and framing tags; DC is zeroed here.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= feed;
      if (feed) begin
        s1_dat.a     <= feed_first ? '0 : abs_ext(xk_re);
        s1_dat.b     <= feed_first ? '0 : abs_ext(xk_im);
        s1_dat.band  <= xk_index[BAND_SH +: BAND_W];
        s1_dat.first <= feed_first;
        s1_dat.last  <= feed_last;
      end
    end
  end

  assign mx    = (s1_dat.a >= s1_dat.b) ? s1_dat.a : s1_dat.b;
  assign mn    = (s1_dat.a >= s1_dat.b) ? s1_dat.b : s1_dat.a;
  assign mag_c = mx + (mn >> 2);

  // S2: max + min/4 magnitude; an abort kills whatever was in S1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_dat <= '0;
    end else begin
      s2_vld <= s1_vld & ~abort;
      if (s1_vld) begin
        s2_dat.mag   <= mag_c;
        s2_dat.band  <= s1_dat.band;
        s2_dat.first <= s1_dat.first;
        s2_dat.last  <= s1_dat.last;
      end
    end
  end

  assign sum_c = {1'b0, acc[s2_dat.band]} + (ACC_W+1)'(s2_dat.mag);

  // S3: saturating accumulate; cleared on frame start, abort, and after the bank copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) acc[b] <= '0;
    end else begin
      xfer <= s2_vld & s2_dat.last & ~abort;
      if (abort || xfer || (s2_vld && s2_dat.first)) begin
        for (int b = 0; b < NUM_BANDS; b++) acc[b] <= '0;
      end else if (s2_vld) begin
        acc[s2_dat.band] <= sum_c[ACC_W] ? ACC_MAX : sum_c[ACC_W-1:0];
      end
    end
  end

  // Bank transfer: copy the finished frame only if the previous result has fully drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_load <= 1'b0;
      overrun   <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) bank[b] <= '0;
    end else begin
      bank_load <= 1'b0;
      overrun   <= 1'b0;
      if (xfer) begin
        if (out_state == OUT_IDLE && !bank_load) begin
          for (int b = 0; b < NUM_BANDS; b++) bank[b] <= acc[b];
          bank_load <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  // Output FSM next state: walk band_id through the bank one handshake at a time.
  always_comb begin
    out_next = out_state;
    id_next  = band_id;
    case (out_state)
      OUT_IDLE: begin
        if (bank_load) begin
          out_next = OUT_SEND;
          id_next  = '0;
        end
      end
      OUT_SEND: begin
        if (band_ready) begin
          if (band_id == TOP_BAND) begin
            out_next = OUT_IDLE;
            id_next  = '0;
          end else begin
            id_next = band_id + BAND_W'(1);
          end
        end
      end
      default: begin
        out_next = OUT_IDLE;
        id_next  = '0;
      end
    endcase
  end

  // Output FSM state register and current band pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_state <= OUT_IDLE;
      band_id   <= '0;
    end else begin
      out_state <= out_next;
      band_id   <= id_next;
    end
  end

  assign band_valid  = (out_state == OUT_SEND);
  assign band_energy = band_valid ? bank[band_id] : '0;

endmodule
